// File: rtl/lr35902_irq_pkg.sv
// lr35902_irq_pkg: shared constants and FSM encoding for the interrupt controller
package lr35902_irq_pkg;
  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;
  localparam logic [7:0] ADR_IF = 8'h0f;
  localparam logic [7:0] ADR_IE = 8'hff;
  localparam logic [15:0] DEF_VECTOR_BASE   = 16'h0040;
  localparam logic [15:0] DEF_VECTOR_STRIDE = 16'd8;
  typedef enum logic {IDLE = 1'b0, DISPATCH = 1'b1} state_t;
endpackage

// File: rtl/lr35902_irq_prio.sv
// lr35902_irq_prio: lowest-set-bit priority encoder (bit 0 wins)
module lr35902_irq_prio
  import lr35902_irq_pkg::*;
#(
  parameter int N  = 5,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic [SW-1:0] o_sel,
  output logic          o_found
);
  always_comb begin
    o_sel = '0;
    o_found = |i_req;
    for (int i = N - 1; i >= 0; i--)
      if (i_req[i]) o_sel = SW'(i);
  end
endmodule

// File: rtl/lr35902_irq_ctrl.sv
// lr35902_irq_ctrl: IF/IE interrupt latch, CPU request and ack/vector dispatch
module lr35902_irq_ctrl
  import lr35902_irq_pkg::*;
#(
  parameter int          NUM_IRQ       = 5,
  parameter logic [15:0] VECTOR_BASE   = DEF_VECTOR_BASE,
  parameter logic [15:0] VECTOR_STRIDE = DEF_VECTOR_STRIDE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] i_irq_src,
  input  logic [7:0]         i_reg_adr,
  input  logic [7:0]         i_reg_din,
  output logic [7:0]         o_reg_dout,
  input  logic               i_reg_read,
  input  logic               i_reg_write,
  output logic               o_int_req,
  input  logic               i_int_ack,
  output logic [15:0]        o_int_vector,
  output logic               o_int_vector_valid,
  input  logic               i_int_taken
);
  localparam int SW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  state_t             r_state, w_state_nx;
  logic [NUM_IRQ-1:0] r_if, r_prev, w_rise, w_if_wr, w_clr, w_ack_pend;
  logic [7:0]         r_ie, w_ie_nx, r_dout;
  logic [15:0]        r_vec;
  logic               r_valid, w_found, w_ack;
  logic [SW-1:0]      w_sel;

  assign w_rise     = i_irq_src & ~r_prev;
  assign w_ie_nx    = (i_reg_write && i_reg_adr == ADR_IE) ? i_reg_din : r_ie;
  assign w_ack      = r_state == IDLE && i_int_ack;
  // selection sees an IE write landing in the ack cycle, so a just-disabled source is not dispatched
  assign w_ack_pend = r_if & w_ie_nx[NUM_IRQ-1:0];
  assign w_if_wr    = (i_reg_write && i_reg_adr == ADR_IF) ? i_reg_din[NUM_IRQ-1:0] : r_if;
  assign w_clr      = (w_ack && w_found) ? {{(NUM_IRQ-1){1'b0}}, 1'b1} << w_sel : '0;

  lr35902_irq_prio #(.N(NUM_IRQ), .SW(SW)) u_prio (
    .i_req   (w_ack_pend),
    .o_sel   (w_sel),
    .o_found (w_found)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;

  always_comb
    w_state_nx = (r_state == IDLE) ? (i_int_ack ? DISPATCH : IDLE)
                                   : (i_int_taken ? IDLE : DISPATCH);

  always_comb
    o_int_req = (r_state == IDLE) && |(r_if & r_ie[NUM_IRQ-1:0]);

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_if    <= '0;
      r_prev  <= '0;
      r_ie    <= '0;
      r_dout  <= 8'hff;
      r_vec   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_if   <= (w_if_wr & ~w_clr) | w_rise;
      r_prev <= i_irq_src;
      r_ie   <= w_ie_nx;
      if (i_reg_read)
        r_dout <= (i_reg_adr == ADR_IF) ? {{(8-NUM_IRQ){1'b1}}, r_if}
                : (i_reg_adr == ADR_IE) ? r_ie : 8'hff;
      if (w_ack) begin
        r_vec   <= w_found ? VECTOR_BASE + VECTOR_STRIDE * 16'(w_sel) : 16'h0000;
        r_valid <= 1'b1;
      end else if (r_state == DISPATCH && i_int_taken)
        r_valid <= 1'b0;
    end

  assign o_reg_dout         = r_dout;
  assign o_int_vector       = r_vec;
  assign o_int_vector_valid = r_valid;
endmodule

// File: tb/tb_lr35902_irq_ctrl.sv
// tb_lr35902_irq_ctrl: directed stimulus, per-cycle model compare plus literal checks
module tb_lr35902_irq_ctrl;
  logic       clk = 1'b0, reset = 1'b1;
  logic [4:0] irq_src = '0;
  logic [7:0] reg_adr = '0, reg_din = '0, reg_dout;
  logic       reg_read = 0, reg_write = 0, int_ack = 0, int_taken = 0;
  logic       int_req, int_vector_valid;
  logic [15:0] int_vector;
  int n_cmp = 0, n_bad = 0;

  lr35902_irq_ctrl dut (
    .clk(clk), .reset(reset), .i_irq_src(irq_src), .i_reg_adr(reg_adr), .i_reg_din(reg_din),
    .o_reg_dout(reg_dout), .i_reg_read(reg_read), .i_reg_write(reg_write), .o_int_req(int_req),
    .i_int_ack(int_ack), .o_int_vector(int_vector), .o_int_vector_valid(int_vector_valid),
    .i_int_taken(int_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: IF as a bit list, a busy flag for the dispatch phase, and the pending vector
  bit m_if [5];
  bit m_prev [5];
  logic [7:0] m_ie, m_dout, m_ie_eff;
  logic [15:0] m_vec;
  bit m_busy, m_valid;
  int m_sel;
  bit m_new [5];

  function automatic logic [7:0] if_byte();
    logic [7:0] v = 8'hff;
    for (int i = 0; i < 5; i++) v[i] = m_if[i];
    return v;
  endfunction

  function automatic bit m_req();
    if (m_busy) return 0;
    for (int i = 0; i < 5; i++) if (m_if[i] && m_ie[i]) return 1;
    return 0;
  endfunction

  always @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 5; i++) begin m_if[i] = 0; m_prev[i] = 0; end
      m_ie = 0; m_dout = 8'hff; m_vec = 0; m_busy = 0; m_valid = 0;
    end else begin
      if (reg_read) m_dout = (reg_adr == 8'h0f) ? if_byte() : (reg_adr == 8'hff) ? m_ie : 8'hff;
      m_ie_eff = (reg_write && reg_adr == 8'hff) ? reg_din : m_ie;
      m_sel = -1;
      if (!m_busy && int_ack)
        for (int i = 4; i >= 0; i--) if (m_if[i] && m_ie_eff[i]) m_sel = i;
      for (int i = 0; i < 5; i++) begin
        m_new[i] = (reg_write && reg_adr == 8'h0f) ? reg_din[i] : m_if[i];
        if (m_sel == i) m_new[i] = 0;
        if (irq_src[i] && !m_prev[i]) m_new[i] = 1;
      end
      if (!m_busy && int_ack) begin
        m_busy = 1; m_valid = 1;
        m_vec = (m_sel < 0) ? 16'h0000 : 16'(16'h0040 + 8 * m_sel);
      end else if (m_busy && int_taken) begin
        m_busy = 0; m_valid = 0;
      end
      for (int i = 0; i < 5; i++) begin m_if[i] = m_new[i]; m_prev[i] = irq_src[i]; end
      m_ie = m_ie_eff;
    end

  always @(negedge clk)
    if (!reset) begin
      chk("int_req", 16'(int_req), 16'(m_req()));
      chk("vec_valid", 16'(int_vector_valid), 16'(m_valid));
      chk("vector", int_vector, m_vec);
      chk("reg_dout", 16'(reg_dout), 16'(m_dout));
    end

  task automatic step();
    @(negedge clk);
    reg_read = 0; reg_write = 0; int_ack = 0; int_taken = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    reg_write = 1; reg_adr = a; reg_din = d; step();
  endtask

  task automatic rd(input string name, input logic [7:0] a, input logic [7:0] exp);
    reg_read = 1; reg_adr = a; step();
    chk(name, 16'(reg_dout), 16'(exp));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_dout", 16'(reg_dout), 16'h00ff);
    chk("rst_valid", 16'(int_vector_valid), 16'h0);
    reset = 0;
    step();
    rd("rst_if", 8'h0f, 8'he0);
    rd("rst_ie", 8'hff, 8'h00);
    rd("other", 8'h44, 8'hff);
    // vblank enabled, level held through ack/taken
    wr(8'hff, 8'h01);
    irq_src = 5'h01; step();
    rd("if_vblank", 8'h0f, 8'he1);
    chk("req_vblank", 16'(int_req), 16'h1);
    int_ack = 1; step();
    chk("vec_vblank", int_vector, 16'h0040);
    int_taken = 1; step();
    rd("no_reset_level", 8'h0f, 8'he0);
    irq_src = 0; step();
    // priority: stat then timer
    wr(8'hff, 8'h1f); wr(8'h0f, 8'h16);
    chk("req_16", 16'(int_req), 16'h1);
    int_ack = 1; step();
    chk("vec_stat", int_vector, 16'h0048);
    chk("valid_stat", 16'(int_vector_valid), 16'h1);
    int_ack = 1; rd("if_f4", 8'h0f, 8'hf4);
    chk("ack_ignored", int_vector, 16'h0048);
    int_taken = 1; step();
    chk("valid_drop", 16'(int_vector_valid), 16'h0);
    int_taken = 1; step();
    int_ack = 1; step();
    chk("vec_timer", int_vector, 16'h0050);
    int_taken = 1; step();
    // IE cleared in the ack cycle -> null vector
    wr(8'h0f, 8'h01); wr(8'hff, 8'h01);
    int_ack = 1; reg_write = 1; reg_adr = 8'hff; reg_din = 8'h00; step();
    chk("vec_null", int_vector, 16'h0000);
    chk("valid_null", 16'(int_vector_valid), 16'h1);
    rd("if_kept", 8'h0f, 8'he1);
    int_taken = 1; step();
    // rise beats IF write and ack clear
    irq_src = 5'h04; reg_write = 1; reg_adr = 8'h0f; reg_din = 8'h00; step();
    rd("rise_vs_wr", 8'h0f, 8'he4);
    irq_src = 0; wr(8'hff, 8'h04);
    irq_src = 5'h04; int_ack = 1; step();
    chk("vec_timer2", int_vector, 16'h0050);
    rd("rise_vs_clr", 8'h0f, 8'he4);
    // async reset during dispatch
    irq_src = 0;
    #2 reset = 1;
    #1 chk("async_valid", 16'(int_vector_valid), 16'h0);
    chk("async_req", 16'(int_req), 16'h0);
    @(negedge clk); reset = 0; step();
    rd("post_rst_if", 8'h0f, 8'he0);
    wr(8'hff, 8'h01);
    irq_src = 5'h01; step();
    int_ack = 1; step();
    chk("post_rst_vec", int_vector, 16'h0040);
    int_taken = 1; step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
